// File: rtl/fcvt_int2fp_pipe.sv
// Pipelined integer to IEEE-754 single-precision converter (FCVT.S.W/WU/L/LU).
// Three register stages: operand capture, normalise, round/pack into the output register.
// Optional feature macro FCVT_ROUND_MODES_EN: when defined, frm_i selects RNE/RTZ/RDN/RUP/RMM;
// when undefined every conversion rounds to nearest-even and frm_i is ignored.
module fcvt_int2fp_pipe #(
    parameter int unsigned INT_W = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [INT_W-1:0] rs1_i,
    input  logic             fcvtU_i,
    input  logic [2:0]       frm_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      fcvtOut_o,
    output logic             nx_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam int unsigned LZC_W    = $clog2(INT_W);
    localparam int unsigned EXP_BASE = 127 + INT_W - 1;

    // Whole pipeline moves together whenever the output slot is free or being drained
    logic advance;
    assign advance    = ~out_valid_o | out_ready_i;
    assign in_ready_o = advance;

    // Stage 1 inputs: sign and absolute magnitude (most negative value maps to its exact magnitude)
    logic             inSign;
    logic [INT_W-1:0] inMag;
    always_comb begin
        inSign = rs1_i[INT_W-1] & ~fcvtU_i;
        inMag  = inSign ? (~rs1_i + {{(INT_W-1){1'b0}}, 1'b1}) : rs1_i;
    end

    logic             s1Valid;
    logic             s1Sign;
    logic [INT_W-1:0] s1Mag;
    logic [TAG_W-1:0] s1Tag;
`ifdef FCVT_ROUND_MODES_EN
    logic [2:0]       s1Frm;
    logic [2:0]       s2Frm;
`else
    logic             unusedFrm;
    assign unusedFrm = ^frm_i;
`endif

    // Stage 1 register: operand capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1Valid <= 1'b0;
            s1Sign  <= 1'b0;
            s1Mag   <= '0;
            s1Tag   <= '0;
`ifdef FCVT_ROUND_MODES_EN
            s1Frm   <= 3'd0;
`endif
        end else if (flush_i) begin
            s1Valid <= 1'b0;
        end else if (advance) begin
            s1Valid <= in_valid_i;
            s1Sign  <= inSign;
            s1Mag   <= inMag;
            s1Tag   <= tag_i;
`ifdef FCVT_ROUND_MODES_EN
            s1Frm   <= frm_i;
`endif
        end
    end

    // Leading-zero count and left-normalisation of the magnitude
    logic [LZC_W-1:0] lzc;
    logic [INT_W-1:0] normC;
    logic [7:0]       expC;
    always_comb begin
        lzc = '0;
        for (int unsigned i = 0; i < INT_W; i++) begin
            if (s1Mag[i]) lzc = LZC_W'(INT_W - 1 - i);
        end
        normC = s1Mag << lzc;
        expC  = 8'(EXP_BASE) - 8'(lzc);
    end

    logic             s2Valid;
    logic             s2Sign;
    logic             s2Zero;
    logic [INT_W-1:0] s2Norm;
    logic [7:0]       s2Exp;
    logic [TAG_W-1:0] s2Tag;

    // Stage 2 register: normalised significand and biased exponent
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s2Valid <= 1'b0;
            s2Sign  <= 1'b0;
            s2Zero  <= 1'b0;
            s2Norm  <= '0;
            s2Exp   <= 8'd0;
            s2Tag   <= '0;
`ifdef FCVT_ROUND_MODES_EN
            s2Frm   <= 3'd0;
`endif
        end else if (flush_i) begin
            s2Valid <= 1'b0;
        end else if (advance) begin
            s2Valid <= s1Valid;
            s2Sign  <= s1Sign;
            s2Zero  <= ~|s1Mag;
            s2Norm  <= normC;
            s2Exp   <= expC;
            s2Tag   <= s1Tag;
`ifdef FCVT_ROUND_MODES_EN
            s2Frm   <= s1Frm;
`endif
        end
    end

    // Round to a 24-bit significand with guard/sticky and pack the single-precision word
    logic [23:0] sig;
    logic        guard;
    logic        sticky;
    logic [2:0]  mode;
    logic        roundUp;
    logic [24:0] sum;
    logic [7:0]  expR;
    logic [22:0] fracR;
    logic [31:0] resC;
    logic        nxC;
    always_comb begin
        sig    = s2Norm[INT_W-1 -: 24];
        guard  = s2Norm[INT_W-25];
        sticky = |s2Norm[INT_W-26:0];
`ifdef FCVT_ROUND_MODES_EN
        mode   = s2Frm;
`else
        mode   = 3'b000;
`endif
        case (mode)
            3'b001:  roundUp = 1'b0;
            3'b010:  roundUp = (guard | sticky) & s2Sign;
            3'b011:  roundUp = (guard | sticky) & ~s2Sign;
            3'b100:  roundUp = guard;
            default: roundUp = guard & (sticky | sig[0]);
        endcase
        sum = {1'b0, sig} + {24'd0, roundUp};
        if (sum[24]) begin
            expR  = s2Exp + 8'd1;
            fracR = 23'd0;
        end else begin
            expR  = s2Exp;
            fracR = sum[22:0];
        end
        resC = s2Zero ? 32'd0 : {s2Sign, expR, fracR};
        nxC  = guard | sticky;
    end

    // Output register: result held while the consumer stalls
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            fcvtOut_o   <= 32'd0;
            nx_o        <= 1'b0;
            tag_o       <= '0;
        end else if (flush_i) begin
            out_valid_o <= 1'b0;
        end else if (advance) begin
            out_valid_o <= s2Valid;
            if (s2Valid) begin
                fcvtOut_o <= resC;
                nx_o      <= nxC;
                tag_o     <= s2Tag;
            end
        end
    end

endmodule
